// File: rtl/pipelined_control_unit.sv
// Pipelined RV32I control unit.
// Decodes the instruction in D and carries its control bundle through E, M and W.
// The branch/jump PC select is resolved in E.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_d, valid_d         instruction in D and its valid flag (0 = bubble)
//   stall_e, flush_e         hold E / load a bubble into E (flush wins)
//   zero_e, lt_e, ltu_e      ALU flags for the instruction in E
//   ImmSrc_d                 immediate select, combinational from instr_d
//   ALUSrc_e, ALUControl_e   ALU operand-B select and operation in E
//   PCSrc_e, illegal_e       take branch/jump target; instruction in E is illegal
//   MemWrite_m               store enable in M
//   RegWrite_m/_w            register write in M and W
//   ResultSrc_m/_w           result select in M and W (00 ALU, 01 mem, 10 PC+4)
module pipelined_control_unit #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter bit          SHIFT_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_d,
  input  logic                 valid_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  output logic [1:0]           ImmSrc_d,
  output logic                 ALUSrc_e,
  output logic [ALUCTRL_W-1:0] ALUControl_e,
  output logic                 PCSrc_e,
  output logic                 illegal_e,
  output logic                 MemWrite_m,
  output logic                 RegWrite_m,
  output logic                 RegWrite_w,
  output logic [1:0]           ResultSrc_m,
  output logic [1:0]           ResultSrc_w
);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSlt  = 4'd5;
  localparam logic [3:0] AluSltu = 4'd6;
  localparam logic [3:0] AluSll  = 4'd7;
  localparam logic [3:0] AluSrl  = 4'd8;
  localparam logic [3:0] AluSra  = 4'd9;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       branch;
    logic       jump;
  } ctrl_t;

  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign op     = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];

  // Register and immediate fields are not needed for control decode.
  logic unused_instr;
  assign unused_instr = ^{instr_d[24:15], instr_d[11:7]};

  ctrl_t      raw, ctrl_d;
  logic [1:0] imm_raw;
  logic       ill_raw, ill_d;

  always_comb begin
    raw     = '0;
    imm_raw = 2'b00;
    ill_raw = 1'b0;
    unique case (op)
      7'b0000011: begin
        raw.reg_write  = 1'b1;
        raw.alu_src    = 1'b1;
        raw.result_src = 2'b01;
      end
      7'b0100011: begin
        imm_raw       = 2'b01;
        raw.alu_src   = 1'b1;
        raw.mem_write = 1'b1;
      end
      7'b0110011, 7'b0010011: begin
        raw.reg_write = 1'b1;
        raw.alu_src   = (op == 7'b0010011);
        if (op == 7'b0110011 && funct7 != 7'b0000000 && funct7 != 7'b0100000) ill_raw = 1'b1;
        unique case (funct3)
          3'b000: raw.alu_ctrl = (op == 7'b0110011 && funct7[5]) ? AluSub : AluAdd;
          3'b001: begin
            raw.alu_ctrl = AluSll;
            if (!SHIFT_EN) ill_raw = 1'b1;
          end
          3'b010: raw.alu_ctrl = AluSlt;
          3'b011: raw.alu_ctrl = AluSltu;
          3'b100: raw.alu_ctrl = AluXor;
          3'b101: begin
            raw.alu_ctrl = funct7[5] ? AluSra : AluSrl;
            if (!SHIFT_EN) ill_raw = 1'b1;
          end
          3'b110: raw.alu_ctrl = AluOr;
          default: raw.alu_ctrl = AluAnd;
        endcase
      end
      7'b1100011: begin
        imm_raw      = 2'b10;
        raw.branch   = 1'b1;
        raw.alu_ctrl = AluSub;
        if (funct3 == 3'b010 || funct3 == 3'b011) ill_raw = 1'b1;
      end
      7'b1101111: begin
        raw.reg_write  = 1'b1;
        imm_raw        = 2'b11;
        raw.result_src = 2'b10;
        raw.jump       = 1'b1;
      end
      default: ill_raw = 1'b1;
    endcase
  end

  // Bubbles and illegal encodings carry all-zero controls; only real instructions can be illegal.
  assign ill_d    = valid_d & ill_raw;
  assign ctrl_d   = (valid_d && !ill_raw) ? raw : '0;
  assign ImmSrc_d = (valid_d && !ill_raw) ? imm_raw : 2'b00;

  ctrl_t      ctrl_e_q;
  logic [2:0] funct3_e_q;
  logic       ill_e_q;
  logic       reg_write_m_q, mem_write_m_q, reg_write_w_q;
  logic [1:0] result_src_m_q, result_src_w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e_q       <= '0;
      funct3_e_q     <= 3'b000;
      ill_e_q        <= 1'b0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
    end else begin
      if (flush_e) begin
        ctrl_e_q   <= '0;
        funct3_e_q <= 3'b000;
        ill_e_q    <= 1'b0;
      end else if (!stall_e) begin
        ctrl_e_q   <= ctrl_d;
        funct3_e_q <= ctrl_d.branch ? funct3 : 3'b000;
        ill_e_q    <= ill_d;
      end
      // A held E instruction must not also advance, so M takes a bubble during a stall.
      if (stall_e) begin
        reg_write_m_q  <= 1'b0;
        mem_write_m_q  <= 1'b0;
        result_src_m_q <= 2'b00;
      end else begin
        reg_write_m_q  <= ctrl_e_q.reg_write;
        mem_write_m_q  <= ctrl_e_q.mem_write;
        result_src_m_q <= ctrl_e_q.result_src;
      end
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
    end
  end

  logic cond_e;
  always_comb begin
    cond_e = 1'b0;
    unique case (funct3_e_q)
      3'b000:  cond_e = zero_e;
      3'b001:  cond_e = ~zero_e;
      3'b100:  cond_e = lt_e;
      3'b101:  cond_e = ~lt_e;
      3'b110:  cond_e = ltu_e;
      3'b111:  cond_e = ~ltu_e;
      default: cond_e = 1'b0;
    endcase
  end

  assign PCSrc_e      = ctrl_e_q.jump | (ctrl_e_q.branch & cond_e);
  assign ALUSrc_e     = ctrl_e_q.alu_src;
  assign ALUControl_e = ALUCTRL_W'(ctrl_e_q.alu_ctrl);
  assign illegal_e    = ill_e_q;
  assign MemWrite_m   = mem_write_m_q;
  assign RegWrite_m   = reg_write_m_q;
  assign ResultSrc_m  = result_src_m_q;
  assign RegWrite_w   = reg_write_w_q;
  assign ResultSrc_w  = result_src_w_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

  logic        clk, rst;
  logic [31:0] instr_d;
  logic        valid_d, stall_e, flush_e, zero_e, lt_e, ltu_e;
  logic [1:0]  ImmSrc_d, ResultSrc_m, ResultSrc_w;
  logic        ALUSrc_e, PCSrc_e, illegal_e, MemWrite_m, RegWrite_m, RegWrite_w;
  logic [3:0]  ALUControl_e;
  logic [1:0]  ImmSrc_d_0, ResultSrc_m_0, ResultSrc_w_0;
  logic        ALUSrc_e_0, PCSrc_e_0, illegal_e_0, MemWrite_m_0, RegWrite_m_0, RegWrite_w_0;
  logic [3:0]  ALUControl_e_0;

  pipelined_control_unit #(.ALUCTRL_W(4), .SHIFT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .ImmSrc_d(ImmSrc_d),
    .ALUSrc_e(ALUSrc_e), .ALUControl_e(ALUControl_e), .PCSrc_e(PCSrc_e),
    .illegal_e(illegal_e), .MemWrite_m(MemWrite_m), .RegWrite_m(RegWrite_m),
    .RegWrite_w(RegWrite_w), .ResultSrc_m(ResultSrc_m), .ResultSrc_w(ResultSrc_w)
  );

  pipelined_control_unit #(.ALUCTRL_W(4), .SHIFT_EN(1'b0)) dut_noshift (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
    .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .ImmSrc_d(ImmSrc_d_0),
    .ALUSrc_e(ALUSrc_e_0), .ALUControl_e(ALUControl_e_0), .PCSrc_e(PCSrc_e_0),
    .illegal_e(illegal_e_0), .MemWrite_m(MemWrite_m_0), .RegWrite_m(RegWrite_m_0),
    .RegWrite_w(RegWrite_w_0), .ResultSrc_m(ResultSrc_m_0), .ResultSrc_w(ResultSrc_w_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle: {reg_write, mem_write, result_src, alu_src, alu_ctrl, illegal}
  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] rs;
    logic       as;
    logic [3:0] alu;
    logic       ill;
  } bun_t;

  localparam bun_t B_NOP  = {1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0};
  localparam bun_t B_ILL  = {1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b1};
  localparam bun_t B_LW   = {1'b1, 1'b0, 2'b01, 1'b1, 4'd0, 1'b0};
  localparam bun_t B_SW   = {1'b0, 1'b1, 2'b00, 1'b1, 4'd0, 1'b0};
  localparam bun_t B_ADD  = {1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0};
  localparam bun_t B_SUB  = {1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 1'b0};
  localparam bun_t B_SRA  = {1'b1, 1'b0, 2'b00, 1'b0, 4'd9, 1'b0};
  localparam bun_t B_XOR  = {1'b1, 1'b0, 2'b00, 1'b0, 4'd4, 1'b0};
  localparam bun_t B_SRAI = {1'b1, 1'b0, 2'b00, 1'b1, 4'd9, 1'b0};
  localparam bun_t B_BR   = {1'b0, 1'b0, 2'b00, 1'b0, 4'd1, 1'b0};
  localparam bun_t B_JAL  = {1'b1, 1'b0, 2'b10, 1'b0, 4'd0, 1'b0};

  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_SRAI = 32'h4010D193;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_B010 = 32'h0020A463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BADOP = 32'h0000007F;
  localparam logic [31:0] I_BADF7 = 32'h022081B3;

  int   checks = 0;
  int   errors = 0;
  bun_t exp_e;
  bun_t sb_q[$];  // in-flight M/W expectations: [0] = W, [1] = M

  // Drive one cycle; the expected bundle for the D instruction is pushed through the scoreboard.
  task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                      input logic r, input bun_t dx);
    bun_t new_m;
    instr_d = ins; valid_d = v; stall_e = st; flush_e = fl; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_e = B_NOP;
      sb_q.delete();
      sb_q.push_back(B_NOP);
      sb_q.push_back(B_NOP);
    end else begin
      new_m = st ? B_NOP : exp_e;
      if (fl) exp_e = B_NOP;
      else if (!st) exp_e = dx;
      sb_q.push_back(new_m);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic test_reset();
    step(I_LW, 1'b1, 1'b0, 1'b0, 1'b1, B_LW);
    step(I_LW, 1'b1, 1'b0, 1'b0, 1'b1, B_LW);
    checks++;
    if ({ALUSrc_e, ALUControl_e, illegal_e, PCSrc_e, MemWrite_m, RegWrite_m, ResultSrc_m,
         RegWrite_w, ResultSrc_w} !== 14'b0) begin
      errors++;
      $display("FAIL reset_outputs: got as=%b alu=%h ill=%b pc=%b mw=%b rwm=%b rsm=%b rww=%b rsw=%b required all 0",
               ALUSrc_e, ALUControl_e, illegal_e, PCSrc_e, MemWrite_m, RegWrite_m, ResultSrc_m,
               RegWrite_w, ResultSrc_w);
    end
    checks++;
    if (ImmSrc_d !== 2'b00) begin
      errors++;
      $display("FAIL reset_immsrc_lw: got %b required 00", ImmSrc_d);
    end
    step(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, B_LW);
    checks++;
    if ({ALUSrc_e, ALUControl_e, illegal_e} !== {exp_e.as, exp_e.alu, exp_e.ill}) begin
      errors++;
      $display("FAIL reset_lw_at_e: got %b required %b", {ALUSrc_e, ALUControl_e, illegal_e},
               {exp_e.as, exp_e.alu, exp_e.ill});
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
    checks++;
    if ({RegWrite_w, ResultSrc_w} !== {sb_q[0].rw, sb_q[0].rs} || ResultSrc_w !== 2'b01) begin
      errors++;
      $display("FAIL reset_lw_at_w: got rw=%b rs=%b required rw=1 rs=01", RegWrite_w, ResultSrc_w);
    end
  endtask

  task automatic test_alu_stream();
    logic [31:0] ins[5];
    bun_t        ex[5];
    bun_t        ex0;
    ins = '{I_ADD, I_SUB, I_SRA, I_XOR, I_SRAI};
    ex  = '{B_ADD, B_SUB, B_SRA, B_XOR, B_SRAI};
    for (int i = 0; i < 5; i++) begin
      step(ins[i], 1'b1, 1'b0, 1'b0, 1'b0, ex[i]);
      checks++;
      if ({ALUSrc_e, ALUControl_e, illegal_e} !== {exp_e.as, exp_e.alu, exp_e.ill}) begin
        errors++;
        $display("FAIL alu_stream_e[%0d]: got %b required %b", i,
                 {ALUSrc_e, ALUControl_e, illegal_e}, {exp_e.as, exp_e.alu, exp_e.ill});
      end
      ex0 = (i == 2 || i == 4) ? B_ILL : ex[i];
      checks++;
      if ({ALUSrc_e_0, ALUControl_e_0, illegal_e_0} !== {ex0.as, ex0.alu, ex0.ill}) begin
        errors++;
        $display("FAIL noshift_e[%0d]: got %b required %b", i,
                 {ALUSrc_e_0, ALUControl_e_0, illegal_e_0}, {ex0.as, ex0.alu, ex0.ill});
      end
      checks++;
      if ({RegWrite_m, MemWrite_m, ResultSrc_m} !== {sb_q[1].rw, sb_q[1].mw, sb_q[1].rs}) begin
        errors++;
        $display("FAIL alu_stream_m[%0d]: got %b required %b", i,
                 {RegWrite_m, MemWrite_m, ResultSrc_m}, {sb_q[1].rw, sb_q[1].mw, sb_q[1].rs});
      end
    end
  endtask

  task automatic test_branch();
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
    instr_d = I_BNE; valid_d = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    #1;
    checks++;
    if (ImmSrc_d !== 2'b10) begin
      errors++;
      $display("FAIL branch_immsrc: got %b required 10", ImmSrc_d);
    end
    step(I_BNE, 1'b1, 1'b0, 1'b0, 1'b0, B_BR);
    checks++;
    if ({ALUSrc_e, ALUControl_e} !== {exp_e.as, exp_e.alu}) begin
      errors++;
      $display("FAIL branch_alu_e: got %b required %b", {ALUSrc_e, ALUControl_e},
               {exp_e.as, exp_e.alu});
    end
    zero_e = 1'b0; #1;
    checks++;
    if (PCSrc_e !== 1'b1) begin
      errors++;
      $display("FAIL bne_taken: got %b required 1", PCSrc_e);
    end
    zero_e = 1'b1; #1;
    checks++;
    if (PCSrc_e !== 1'b0) begin
      errors++;
      $display("FAIL bne_not_taken: got %b required 0", PCSrc_e);
    end
    step(I_BGEU, 1'b1, 1'b0, 1'b0, 1'b0, B_BR);
    zero_e = 1'b0; ltu_e = 1'b1; #1;
    checks++;
    if (PCSrc_e !== 1'b0) begin
      errors++;
      $display("FAIL bgeu_ltu1: got %b required 0", PCSrc_e);
    end
    ltu_e = 1'b0; #1;
    checks++;
    if (PCSrc_e !== 1'b1) begin
      errors++;
      $display("FAIL bgeu_ltu0: got %b required 1", PCSrc_e);
    end
    instr_d = I_JAL; #1;
    checks++;
    if (ImmSrc_d !== 2'b11) begin
      errors++;
      $display("FAIL jal_immsrc: got %b required 11", ImmSrc_d);
    end
    step(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, B_JAL);
    for (int k = 0; k < 8; k++) begin
      {zero_e, lt_e, ltu_e} = 3'(k);
      #1;
      checks++;
      if (PCSrc_e !== 1'b1) begin
        errors++;
        $display("FAIL jal_flags%0d: got %b required 1", k, PCSrc_e);
      end
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
    checks++;
    if (PCSrc_e !== 1'b0) begin
      errors++;
      $display("FAIL bubble_pcsrc: got %b required 0", PCSrc_e);
    end
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
  endtask

  task automatic test_stall();
    int mw_count;
    instr_d = I_SW; valid_d = 1'b1; #1;
    checks++;
    if (ImmSrc_d !== 2'b01) begin
      errors++;
      $display("FAIL sw_immsrc: got %b required 01", ImmSrc_d);
    end
    step(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, B_SW);
    for (int i = 0; i < 2; i++) begin
      step(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, B_NOP);
      checks++;
      if (ALUSrc_e !== 1'b1 || MemWrite_m !== sb_q[1].mw || MemWrite_m !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got as=%b mw=%b required as=1 mw=0", i, ALUSrc_e,
                 MemWrite_m);
      end
    end
    mw_count = 0;
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
      if (MemWrite_m === 1'b1) mw_count++;
      checks++;
      if (MemWrite_m !== sb_q[1].mw) begin
        errors++;
        $display("FAIL stall_release[%0d]: got mw=%b required %b", i, MemWrite_m, sb_q[1].mw);
      end
    end
    checks++;
    if (mw_count != 1) begin
      errors++;
      $display("FAIL stall_store_once: got %0d stores required 1", mw_count);
    end
  endtask

  task automatic test_flush_stall();
    step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, B_ADD);
    step(I_LW, 1'b1, 1'b1, 1'b1, 1'b0, B_LW);
    checks++;
    if ({ALUSrc_e, ALUControl_e, illegal_e} !== 6'b0) begin
      errors++;
      $display("FAIL flush_wins_e: got %b required 000000", {ALUSrc_e, ALUControl_e, illegal_e});
    end
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
      checks++;
      if ({RegWrite_m, ResultSrc_m, RegWrite_w, ResultSrc_w} !== 6'b0) begin
        errors++;
        $display("FAIL flush_lw_gone[%0d]: got rwm=%b rsm=%b rww=%b rsw=%b required all 0", i,
                 RegWrite_m, ResultSrc_m, RegWrite_w, ResultSrc_w);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins[3];
    ins = '{I_BADOP, I_B010, I_BADF7};
    for (int i = 0; i < 3; i++) begin
      step(ins[i], 1'b1, 1'b0, 1'b0, 1'b0, B_ILL);
      checks++;
      if ({ALUSrc_e, ALUControl_e, illegal_e, PCSrc_e} !== 7'b0000010 || ImmSrc_d !== 2'b00)
      begin
        errors++;
        $display("FAIL illegal_e[%0d]: got as=%b alu=%h ill=%b pc=%b imm=%b required ill=1 rest 0",
                 i, ALUSrc_e, ALUControl_e, illegal_e, PCSrc_e, ImmSrc_d);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
      checks++;
      if ({RegWrite_m, MemWrite_m} !== {sb_q[1].rw, sb_q[1].mw} || RegWrite_m !== 1'b0) begin
        errors++;
        $display("FAIL illegal_m[%0d]: got rw=%b mw=%b required 0 0", i, RegWrite_m, MemWrite_m);
      end
    end
  endtask

  task automatic test_midstream_reset();
    step(I_LW, 1'b1, 1'b0, 1'b0, 1'b0, B_LW);
    step(I_SW, 1'b1, 1'b0, 1'b0, 1'b0, B_SW);
    step(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, B_JAL);
    step(I_ADD, 1'b1, 1'b0, 1'b0, 1'b1, B_ADD);
    checks++;
    if ({ALUSrc_e, ALUControl_e, illegal_e, PCSrc_e, MemWrite_m, RegWrite_m, ResultSrc_m,
         RegWrite_w, ResultSrc_w} !== 14'b0) begin
      errors++;
      $display("FAIL midstream_reset: got as=%b alu=%h pc=%b mw=%b rwm=%b rsm=%b rww=%b rsw=%b",
               ALUSrc_e, ALUControl_e, PCSrc_e, MemWrite_m, RegWrite_m, ResultSrc_m,
               RegWrite_w, ResultSrc_w);
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, B_NOP);
  endtask

  initial begin
    rst = 1'b1; instr_d = 32'h0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
    exp_e = B_NOP;
    sb_q.push_back(B_NOP);
    sb_q.push_back(B_NOP);
    test_reset();
    test_alu_stream();
    test_branch();
    test_stall();
    test_flush_stall();
    test_illegal();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
